// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// Covers the controller state encoding, geometry widths and byte-lane access.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE
  } cache_state_t;

  // Byte helpers operate on a fixed wide word; callers resize to DATA_WIDTH.
  localparam int unsigned MAX_DW = 64;

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned aw, input int unsigned sets);
    return aw - 2 - $clog2(sets);
  endfunction

  function automatic logic [7:0] byte_select(input logic [MAX_DW-1:0] w, input logic [1:0] off);
    return w[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] w,
                                                  input logic [1:0]        off,
                                                  input logic [7:0]        b);
    logic [MAX_DW-1:0] r;
    r = w;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set age-based LRU state for an N-way cache.
// One instance serves all sets; the caller selects the set for both query and touch.
module cache_lru #(
  parameter  int unsigned SETS  = 8,
  parameter  int unsigned WAYS  = 2,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic             touch_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic             found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch_i) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < age_q[set_i][touch_way_i]) begin
          age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
        end
      end
    end
  end

  // Invalid ways are filled lowest-index first before anything is evicted.
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
          victim_o = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/data_cache_nway.sv
// N-way set-associative, write-through, no-write-allocate data cache.
// Hits return data combinationally; misses and all stores go to memory via req/ack.
module data_cache_nway
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SETS       = 8,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RE,
  input  logic                  WE,
  input  logic                  ByteAddr,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  Stall,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWD,
  output logic                  MemByte,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemRD,
  output logic [CNT_WIDTH-1:0]  HitCount,
  output logic [CNT_WIDTH-1:0]  MissCount
);

  localparam int unsigned IDX_W = idx_width(SETS);
  localparam int unsigned TAG_W = tag_width(ADDR_WIDTH, SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  cache_state_t          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  byte_q;
  logic [WAY_W-1:0]      victim_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [IDX_W-1:0]      lk_set;
  logic [TAG_W-1:0]      lk_tag;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [WAY_W-1:0]      victim;
  logic                  touch;
  logic [WAY_W-1:0]      touch_way;
  logic                  fill;
  logic                  wr_upd;
  logic [DATA_WIDTH-1:0] store_word;

  function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [DATA_WIDTH-1:0] w,
                                                     input logic                  b,
                                                     input logic [1:0]            off);
    if (b) begin
      return DATA_WIDTH'(byte_select(MAX_DW'(w), off));
    end
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_fmt(input logic [DATA_WIDTH-1:0] old,
                                                      input logic [DATA_WIDTH-1:0] wd,
                                                      input logic                  b,
                                                      input logic [1:0]            off);
    logic [MAX_DW-1:0] merged;
    merged = byte_merge(MAX_DW'(old), off, wd[7:0]);
    if (b) begin
      return merged[DATA_WIDTH-1:0];
    end
    return wd;
  endfunction

  // Outside IDLE the lookup uses the latched access so the ack edge sees the same line.
  assign lk_addr = (state_q == IDLE) ? A : addr_q;
  assign lk_set  = lk_addr[2 +: IDX_W];
  assign lk_tag  = lk_addr[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word   = data_q[lk_set][hit_way];
  assign store_word = store_fmt(hit_word, wd_q, byte_q, addr_q[1:0]);

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .set_i       (lk_set),
    .valid_i     (valid_q[lk_set]),
    .touch_i     (touch),
    .touch_way_i (touch_way),
    .victim_o    (victim)
  );

  always_comb begin
    Stall     = 1'b0;
    RD        = '0;
    touch     = 1'b0;
    touch_way = hit_way;
    fill      = 1'b0;
    wr_upd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Flush || WE) begin
          Stall = 1'b1;
        end else if (RE) begin
          if (hit) begin
            RD    = load_fmt(hit_word, ByteAddr, A[1:0]);
            touch = 1'b1;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      FETCH: begin
        Stall = ~MemAck;
        if (MemAck) begin
          RD        = load_fmt(MemRD, byte_q, addr_q[1:0]);
          fill      = 1'b1;
          touch     = 1'b1;
          touch_way = victim_q;
        end
      end
      WRITE: begin
        Stall = ~MemAck;
        if (MemAck && hit) begin
          wr_upd = 1'b1;
          touch  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wd_q       <= '0;
      byte_q     <= 1'b0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
            end
          end else if (WE) begin
            addr_q  <= A;
            wd_q    <= WD;
            byte_q  <= ByteAddr;
            state_q <= WRITE;
          end else if (RE) begin
            if (hit) begin
              hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end else begin
              addr_q     <= A;
              byte_q     <= ByteAddr;
              victim_q   <= victim;
              miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (MemAck) begin
            valid_q[lk_set][victim_q] <= 1'b1;
            state_q                   <= IDLE;
          end
        end
        WRITE: begin
          if (MemAck) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[lk_set][victim_q] <= MemRD;
      tag_q[lk_set][victim_q]  <= lk_tag;
    end else if (wr_upd) begin
      data_q[lk_set][hit_way] <= store_word;
    end
  end

  assign MemReq    = (state_q != IDLE);
  assign MemWE     = (state_q == WRITE);
  assign MemByte   = (state_q == WRITE) && byte_q;
  assign MemWD     = (state_q == WRITE) ? wd_q : '0;
  assign MemAddr   = (state_q == WRITE) ? addr_q :
                     (state_q == FETCH) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_data_cache_nway.sv
// Directed self-checking bench for data_cache_nway (8 sets, 2 ways).
module tb_data_cache_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RE = 1'b0, WE = 1'b0, ByteAddr = 1'b0, Flush = 1'b0;
  logic [31:0] A = '0, WD = '0;
  logic [31:0] RD;
  logic        Stall, MemReq, MemWE, MemByte;
  logic [31:0] MemAddr, MemWD;
  logic        MemAck = 1'b0;
  logic [31:0] MemRD = '0;
  logic [31:0] HitCount, MissCount;

  int checks = 0;
  int failures = 0;

  data_cache_nway #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .SETS       (8),
    .WAYS       (2),
    .CNT_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RE        (RE),
    .WE        (WE),
    .ByteAddr  (ByteAddr),
    .A         (A),
    .WD        (WD),
    .Flush     (Flush),
    .RD        (RD),
    .Stall     (Stall),
    .MemReq    (MemReq),
    .MemWE     (MemWE),
    .MemAddr   (MemAddr),
    .MemWD     (MemWD),
    .MemByte   (MemByte),
    .MemAck    (MemAck),
    .MemRD     (MemRD),
    .HitCount  (HitCount),
    .MissCount (MissCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; RE = 1'b0; WE = 1'b0; Flush = 1'b0; MemAck = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd_miss(input logic [31:0] addr, input logic b, input logic [31:0] mem,
                         input int lat, input logic [31:0] exp);
    int stalls;
    stalls = 0;
    @(negedge clk);
    RE = 1'b1; A = addr; ByteAddr = b; #1;
    check("miss_idle_stall", {31'd0, Stall}, 32'd1);
    if (Stall) stalls++;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      check("fetch_req", {31'd0, MemReq}, 32'd1);
      check("fetch_we", {31'd0, MemWE}, 32'd0);
      check("fetch_addr", MemAddr, addr & 32'hFFFF_FFFC);
      if (Stall) stalls++;
    end
    @(negedge clk);
    MemAck = 1'b1; MemRD = mem; #1;
    check("ack_stall", {31'd0, Stall}, 32'd0);
    check("ack_rd", RD, exp);
    check("miss_penalty", stalls, 1 + lat);
    @(negedge clk);
    MemAck = 1'b0; MemRD = '0; RE = 1'b0;
  endtask

  task automatic rd_hit(input logic [31:0] addr, input logic b, input logic [31:0] exp);
    @(negedge clk);
    RE = 1'b1; A = addr; ByteAddr = b; #1;
    check("hit_stall", {31'd0, Stall}, 32'd0);
    check("hit_rd", RD, exp);
    @(negedge clk);
    RE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic b, input logic [31:0] wd, input int lat);
    @(negedge clk);
    WE = 1'b1; A = addr; ByteAddr = b; WD = wd; #1;
    check("wr_idle_stall", {31'd0, Stall}, 32'd1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      check("wr_req", {31'd0, MemReq}, 32'd1);
      check("wr_we", {31'd0, MemWE}, 32'd1);
      check("wr_addr", MemAddr, addr);
      check("wr_byte", {31'd0, MemByte}, {31'd0, b});
      check("wr_wd", MemWD, wd);
      check("wr_stall", {31'd0, Stall}, 32'd1);
    end
    @(negedge clk);
    MemAck = 1'b1; #1;
    check("wr_ack_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    MemAck = 1'b0; WE = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_rd", RD, 32'd0);
    check("rst_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_memwe", {31'd0, MemWE}, 32'd0);
    check("rst_membyte", {31'd0, MemByte}, 32'd0);
    check("rst_hits", HitCount, 32'd0);
    check("rst_misses", MissCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: cold miss then hit
    rd_miss(32'h10, 1'b0, 32'hDEADBEEF, 3, 32'hDEADBEEF);
    check("t1_misses", MissCount, 32'd1);
    rd_hit(32'h10, 1'b0, 32'hDEADBEEF);
    check("t1_hits", HitCount, 32'd1);

    // 2: LRU eviction in set 0
    do_reset();
    rd_miss(32'h00, 1'b0, 32'hA0, 3, 32'hA0);
    rd_miss(32'h20, 1'b0, 32'hA1, 3, 32'hA1);
    rd_hit(32'h00, 1'b0, 32'hA0);
    rd_miss(32'h40, 1'b0, 32'hA2, 3, 32'hA2);
    rd_hit(32'h00, 1'b0, 32'hA0);
    rd_miss(32'h20, 1'b0, 32'hA3, 3, 32'hA3);
    check("t2_misses", MissCount, 32'd4);
    check("t2_hits", HitCount, 32'd2);

    // 3: byte store on a cached line
    do_reset();
    rd_miss(32'h10, 1'b0, 32'h11223344, 3, 32'h11223344);
    wr(32'h13, 1'b1, 32'h000000AB, 3);
    rd_hit(32'h13, 1'b1, 32'h000000AB);
    rd_hit(32'h10, 1'b0, 32'hAB223344);
    rd_hit(32'h11, 1'b1, 32'h00000033);

    // 4: store miss does not allocate
    wr(32'h80, 1'b0, 32'hCAFEF00D, 2);
    rd_miss(32'h80, 1'b0, 32'h55, 2, 32'h55);
    check("t4_misses", MissCount, 32'd2);

    // 5: flush
    do_reset();
    rd_miss(32'h00, 1'b0, 32'h1111, 3, 32'h1111);
    rd_miss(32'h04, 1'b0, 32'h2222, 3, 32'h2222);
    @(negedge clk);
    Flush = 1'b1; #1;
    check("flush_stall", {31'd0, Stall}, 32'd1);
    @(negedge clk);
    Flush = 1'b0; #1;
    check("post_flush_stall", {31'd0, Stall}, 32'd0);
    rd_miss(32'h00, 1'b0, 32'h3333, 3, 32'h3333);
    rd_miss(32'h04, 1'b0, 32'h4444, 3, 32'h4444);
    check("t5_misses", MissCount, 32'd4);

    // 6: reset during FETCH
    do_reset();
    @(negedge clk);
    RE = 1'b1; A = 32'h10; ByteAddr = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("t6_req_before", {31'd0, MemReq}, 32'd1);
    #2;
    rst = 1'b1; RE = 1'b0; #1;
    check("t6_req_dropped", {31'd0, MemReq}, 32'd0);
    check("t6_stall", {31'd0, Stall}, 32'd0);
    check("t6_misses", MissCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_miss(32'h10, 1'b0, 32'h77, 3, 32'h77);
    check("t6_misses_after", MissCount, 32'd1);

    // 7: zero-latency ack
    rd_miss(32'h44, 1'b0, 32'h99887766, 0, 32'h99887766);
    rd_miss(32'h4A, 1'b1, 32'h99887766, 0, 32'h00000088);
    rd_hit(32'h44, 1'b0, 32'h99887766);
    rd_hit(32'h49, 1'b1, 32'h00000077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
